board_update_sequencer: RTL
===========================

BOARD_UPDATE_SEQUENCER -- requirements
Module: board_update_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, square address width (row*8+col, row 0 = black back rank).
REQ-002 Parameter PIECE_W, default 4, piece code width {color, type[2:0]}; color 1 = black.
REQ-003 full_clock  input  1  sole clock, rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 init_req  input  1  request reload of the new-game layout.
REQ-006 move_valid  input  1  move request valid.
REQ-007 move_ready  output  1  move request accepted when high with move_valid.
REQ-008 move_src  input  ADDR_W  source square.
REQ-009 move_dst  input  ADDR_W  destination square.
REQ-010 move_piece  input  PIECE_W  piece code written to move_dst.
REQ-011 wr_en  output  1  board write strobe, one square per cycle.
REQ-012 wr_addr  output  ADDR_W  board write address.
REQ-013 wr_piece  output  PIECE_W  board write data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when a move or an init sequence completes.
REQ-016 side_to_move  output  1  0 = white, 1 = black.
REQ-017 move_count  output  8  count of completed moves, wraps 255->0.

Function
REQ-018 States SHALL be IDLE, MOVE_DST, MOVE_SRC and INIT, with a 6-bit init counter.
REQ-019 move_ready SHALL equal (state==IDLE) && !init_req && !init_pend, combinationally.
REQ-020 In IDLE, init_req or init_pend SHALL go to INIT with counter=0 and clear init_pend; init has priority over a simultaneous move_valid.
REQ-021 In IDLE, an accepted move with move_src!=move_dst SHALL latch src, dst and piece and go to MOVE_DST.
REQ-022 An accepted move with move_src==move_dst SHALL be consumed with no write, no done, and no change to side_to_move or move_count; the block stays in IDLE.
REQ-023 MOVE_DST SHALL drive wr_en=1, wr_addr=dst, wr_piece=latched piece for one cycle, then go to MOVE_SRC.
REQ-024 MOVE_SRC SHALL drive wr_en=1, wr_addr=src, wr_piece=0 for one cycle, pulse done, toggle side_to_move, increment move_count, then go to IDLE.
REQ-025 Timing: a move accepted at edge N SHALL present the dst write in cycle N+1 and the src write in cycle N+2; move_ready SHALL be high again in cycle N+3.
REQ-026 INIT SHALL write wr_addr=counter with wr_piece=layout(counter) on each of 64 consecutive cycles, counting 0..63.
REQ-027 Layout: row0 = C,A,B,D,E,B,A,C (hex); row1 = 9; rows 2-5 = 0; row6 = 1; row7 = 4,2,3,5,6,3,2,4.
REQ-028 At counter 63, INIT SHALL pulse done, clear side_to_move and move_count, and return to IDLE.
REQ-029 init_req during MOVE_DST or MOVE_SRC SHALL set init_pend; INIT SHALL start in the cycle after the move's IDLE return.
REQ-030 init_req during INIT SHALL be ignored; the sequence SHALL NOT restart.
REQ-031 In IDLE, wr_en SHALL be 0, and wr_addr and wr_piece SHALL be 0.
REQ-032 move inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect a move in progress.

Reset
REQ-033 Reset SHALL force IDLE, counter=0, init_pend=0, wr_en=0, done=0, busy=0, side_to_move=0, move_count=0, asynchronously.
REQ-034 Reset asserted mid-INIT or mid-move SHALL abort the sequence with no further writes, and SHALL NOT auto-start INIT afterwards.

Verification
REQ-035 Apply init_req for 1 cycle from IDLE -> 64 writes addr 0..63 matching REQ-027 (addr 4=E, 60=6, 8=9, 32=0), then done 1 cycle, busy low.
REQ-036 Apply move src=52, dst=36, piece=1, accepted at edge N -> cycle N+1 write (36,1), cycle N+2 write (52,0) with done=1, side_to_move=1, move_count=1.
REQ-037 Assert init_req and move_valid together in IDLE -> move_ready=0, INIT runs, move accepted only after the init done.
REQ-038 Assert init_req during MOVE_DST -> move completes, then INIT begins the next cycle, and the final state is side_to_move=0, move_count=0.
REQ-039 Issue 256 valid moves -> move_count wraps to 0, side_to_move=0; a src==dst move -> no wr_en, counters unchanged.
REQ-040 Assert Reset at init counter=20 -> wr_en drops immediately, all outputs at reset values, no writes after deassertion.

Source files
------------

// File: rtl/board_update_sequencer_if.sv
// Board update sequencer bus: move request handshake, init request,
// board write port and game status. The master side is the game
// controller; the slave side is the sequencer that updates the board.
interface board_update_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
);
    logic               init_req;
    logic               move_valid;
    logic               move_ready;
    logic [ADDR_W-1:0]  move_src;
    logic [ADDR_W-1:0]  move_dst;
    logic [PIECE_W-1:0] move_piece;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIECE_W-1:0] wr_piece;
    logic               busy;
    logic               done;
    logic               side_to_move;
    logic [7:0]         move_count;

    modport master (
        output init_req, move_valid, move_src, move_dst, move_piece,
        input  move_ready, wr_en, wr_addr, wr_piece, busy, done,
               side_to_move, move_count
    );

    modport slave (
        input  init_req, move_valid, move_src, move_dst, move_piece,
        output move_ready, wr_en, wr_addr, wr_piece, busy, done,
               side_to_move, move_count
    );
endinterface

// File: rtl/board_update_sequencer.sv
// Board update sequencer: turns a move request into two board writes
// (destination gets the piece, source is cleared) and reloads the
// new-game layout one square per cycle on request. Tracks whose turn
// it is and how many moves have been completed since the last init.
module board_update_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
) (
    input  logic                     full_clock,
    input  logic                     Reset,
    board_update_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MOVE_DST = 2'd1;
    localparam logic [1:0] MOVE_SRC = 2'd2;
    localparam logic [1:0] INIT     = 2'd3;

    logic [1:0]         r_state;
    logic [5:0]         r_counter;
    logic               r_initPend;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [PIECE_W-1:0] r_piece;
    logic               r_side;
    logic [7:0]         r_moveCount;

    logic               w_idle;
    logic               w_moveReady;
    logic               w_accept;
    logic               w_initStart;
    logic [2:0]         w_backType;
    logic [3:0]         w_layoutPiece;

    // A pending or fresh init request blocks move acceptance so that init wins.
    assign w_idle      = (r_state == IDLE);
    assign w_moveReady = w_idle && !bus.init_req && !r_initPend;
    assign w_accept    = w_moveReady && bus.move_valid;
    assign w_initStart = w_idle && (bus.init_req || r_initPend);

    assign bus.move_ready   = w_moveReady;
    assign bus.busy         = !w_idle;
    assign bus.side_to_move = r_side;
    assign bus.move_count   = r_moveCount;

    // Back-rank piece type by column: rook, knight, bishop, queen, king, bishop, knight, rook.
    always_comb begin
        w_backType = 3'd0;
        case (r_counter[2:0])
            3'd0:    w_backType = 3'd4;
            3'd1:    w_backType = 3'd2;
            3'd2:    w_backType = 3'd3;
            3'd3:    w_backType = 3'd5;
            3'd4:    w_backType = 3'd6;
            3'd5:    w_backType = 3'd3;
            3'd6:    w_backType = 3'd2;
            default: w_backType = 3'd4;
        endcase
    end

    // New-game layout: black on rows 0-1 (colour bit set), white on rows 6-7, pawns are type 1.
    always_comb begin
        w_layoutPiece = 4'h0;
        case (r_counter[5:3])
            3'd0:    w_layoutPiece = {1'b1, w_backType};
            3'd1:    w_layoutPiece = 4'h9;
            3'd6:    w_layoutPiece = 4'h1;
            3'd7:    w_layoutPiece = {1'b0, w_backType};
            default: w_layoutPiece = 4'h0;
        endcase
    end

    // Board write port and completion pulse are decoded from the current state only.
    always_comb begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_piece = '0;
        bus.done     = 1'b0;
        case (r_state)
            MOVE_DST: begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = r_dst;
                bus.wr_piece = r_piece;
            end
            MOVE_SRC: begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = r_src;
                bus.done     = 1'b1;
            end
            INIT: begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = ADDR_W'(r_counter);
                bus.wr_piece = PIECE_W'(w_layoutPiece);
                bus.done     = (r_counter == 6'd63);
            end
            default: ;
        endcase
    end

    // Sequencer state, latched move and game status; init requests seen mid-move are deferred.
    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_counter   <= 6'd0;
            r_initPend  <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_piece     <= '0;
            r_side      <= 1'b0;
            r_moveCount <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_initStart) begin
                        r_state    <= INIT;
                        r_counter  <= 6'd0;
                        r_initPend <= 1'b0;
                    end else if (w_accept && (bus.move_src != bus.move_dst)) begin
                        r_src   <= bus.move_src;
                        r_dst   <= bus.move_dst;
                        r_piece <= bus.move_piece;
                        r_state <= MOVE_DST;
                    end
                end
                MOVE_DST: begin
                    if (bus.init_req) r_initPend <= 1'b1;
                    r_state <= MOVE_SRC;
                end
                MOVE_SRC: begin
                    if (bus.init_req) r_initPend <= 1'b1;
                    r_side      <= ~r_side;
                    r_moveCount <= r_moveCount + 8'd1;
                    r_state     <= IDLE;
                end
                INIT: begin
                    if (r_counter == 6'd63) begin
                        r_side      <= 1'b0;
                        r_moveCount <= 8'd0;
                        r_state     <= IDLE;
                    end else begin
                        r_counter <= r_counter + 6'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
